// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// State encoding, parity modes and the parity-bit generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        BREAK_WAIT
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit a transmitter would send for this data in this mode.
    function automatic logic calc_parity(input logic [8:0] data, input int mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial input and character/status outputs of the UART receiver.
// master is the receiver side, slave is the consumer/line driver.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Rx_Serial;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;
    logic                 o_Busy;

    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV, o_Rx_Byte, o_Parity_Err,
        output o_Frame_Err, o_Break, o_Busy
    );

    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV, o_Rx_Byte, o_Parity_Err,
        input  o_Frame_Err, o_Break, o_Busy
    );
endinterface

// File: rtl/uart_sync_vote.sv
// 2-FF synchroniser followed by a 3-deep sample history.
// vote is the majority of the three most recent history samples.
module uart_sync_vote (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic line,
    output logic vote
);
    logic       s1;
    logic       s2;
    logic [2:0] hist;

    // Synchronise the line and keep the last three synchronised samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            hist <= 3'b111;
        end else begin
            s1   <= rx;
            s2   <= s1;
            hist <= {hist[1:0], s2};
        end
    end

    assign line = s2;
    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with majority-vote sampling.
// Reports parity/framing errors with each character and detects breaks.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input logic           i_sys_clk,
    input logic           i_rst,
    uart_rx_cfg_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 1023) begin : g_bad_cpb
        $error("CLKS_PER_BIT out of range 8..1023");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS out of range 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    state_t               state;
    state_t               next;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr;
    logic                 zeros;
    logic                 line;
    logic                 vote;
    logic                 tc;
    logic                 brk_set;
    logic                 dv_q;
    logic                 pe_q;
    logic                 fe_q;
    logic                 brk_q;
    logic [DATA_BITS-1:0] byte_q;

    uart_sync_vote u_sync (
        .clk  (i_sys_clk),
        .rst  (i_rst),
        .rx   (bus.i_Rx_Serial),
        .line (line),
        .vote (vote)
    );

    assign tc = (cnt == LAST);

    // State register.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= next;
    end

    // Next-state decode; the frame-end break decision is made here.
    always_comb begin
        next    = state;
        brk_set = 1'b0;
        unique case (state)
            IDLE: if (!line) next = START;
            START: if (cnt == HALF) next = line ? IDLE : DATA;
            DATA: begin
                if (tc && bit_idx == LAST_BIT)
                    next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end
            uart_pkg::PARITY: if (tc) next = STOP;
            STOP: begin
                if (tc && stop_idx == STOP_LAST) begin
                    if (zeros && !vote) begin
                        next    = BREAK_WAIT;
                        brk_set = 1'b1;
                    end else begin
                        next = DONE;
                    end
                end
            end
            DONE: next = IDLE;
            BREAK_WAIT: if (line) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Bit timing counter and per-frame sample capture.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            ferr     <= 1'b0;
            zeros    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    ferr     <= 1'b0;
                    zeros    <= 1'b1;
                end
                START: cnt <= (cnt == HALF) ? '0 : cnt + 1'b1;
                DATA: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        zeros   <= zeros & ~vote;
                    end
                end
                uart_pkg::PARITY: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        par_bit <= vote;
                        zeros   <= zeros & ~vote;
                    end
                end
                STOP: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        stop_idx <= 1'b1;
                        zeros    <= zeros & ~vote;
                        if (!vote) ferr <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Registered outputs: DV and flags pulse for the single DONE cycle.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            dv_q   <= 1'b0;
            pe_q   <= 1'b0;
            fe_q   <= 1'b0;
            brk_q  <= 1'b0;
            byte_q <= '0;
        end else begin
            dv_q  <= (state == DONE);
            pe_q  <= (state == DONE) && (PARITY != PAR_NONE) &&
                     (par_bit != calc_parity(9'(shreg), PARITY));
            fe_q  <= (state == DONE) && ferr;
            brk_q <= brk_set;
            if (state == DONE) byte_q <= shreg;
        end
    end

    assign bus.o_Rx_DV      = dv_q;
    assign bus.o_Rx_Byte    = byte_q;
    assign bus.o_Parity_Err = pe_q;
    assign bus.o_Frame_Err  = fe_q;
    assign bus.o_Break      = brk_q;
    assign bus.o_Busy       = (state != IDLE);
endmodule
